// File: rtl/sram_be_ctrl_if.sv
// Request/grant/rvalid bus between a bus adapter (master) and sram_be_ctrl (slave).
// Signals:
//   req_i, we_i, addr_i, wdata_i, wmask_i : request side, driven by the master
//   gnt_o                                 : request accepted this cycle
//   rvalid_o, rdata_o, rerror_o           : read response, one cycle after a read grant
interface sram_be_ctrl_if #(
  parameter int unsigned Width = 80,
  parameter int unsigned AddrW = 11
);
  localparam int unsigned NumBytes = Width / 8;

  logic                req_i;
  logic                gnt_o;
  logic                we_i;
  logic [AddrW-1:0]    addr_i;
  logic [Width-1:0]    wdata_i;
  logic [NumBytes-1:0] wmask_i;
  logic                rvalid_o;
  logic [Width-1:0]    rdata_o;
  logic                rerror_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, wmask_i,
    input  gnt_o, rvalid_o, rdata_o, rerror_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, wmask_i,
    output gnt_o, rvalid_o, rdata_o, rerror_o
  );
endinterface

// File: rtl/sram_be_ctrl.sv
// Single-port banked SRAM controller with per-byte write enables, a fixed
// 1-cycle read latency, a hardware zero-fill after reset / on request, and
// out-of-range access flagging.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   bus          sram_be_ctrl_if.slave: req/gnt/we/addr/wdata/wmask, rvalid/rdata/rerror
//   init_req_i   pulse: start a zero-fill of the whole array (ignored while filling)
//   init_done_o  1 when no zero-fill is in progress
module sram_be_ctrl #(
  parameter int unsigned Width     = 80,
  parameter int unsigned BankDepth = 512,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned AddrW     = 11
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  sram_be_ctrl_if.slave bus,
  input  logic          init_req_i,
  output logic          init_done_o
);

  localparam int unsigned NumBytes = Width / 8;
  localparam int unsigned Depth    = BankDepth * NumBanks;
  localparam int unsigned RowW     = (BankDepth > 1) ? $clog2(BankDepth) : 1;
  localparam int unsigned BankW    = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int unsigned CntW     = (Depth > 1) ? $clog2(Depth) : 1;

  // Elaboration-time parameter checks
  if ((Width % 8) != 0 || Width == 0) begin : g_chk_width
    $error("sram_be_ctrl: Width must be a non-zero multiple of 8");
  end
  if (BankDepth == 0 || (BankDepth & (BankDepth - 1)) != 0) begin : g_chk_depth
    $error("sram_be_ctrl: BankDepth must be a power of two");
  end
  if (AddrW < CntW || AddrW > 32) begin : g_chk_addrw
    $error("sram_be_ctrl: AddrW must cover Depth and be at most 32");
  end

  typedef enum logic {
    StInit  = 1'b0,
    StReady = 1'b1
  } state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                init_done_q;
  logic                rvalid_q;
  logic                rerror_q;
  logic [Width-1:0]    rdata_q;

  logic [Width-1:0]    mem_q [NumBanks][BankDepth];

  logic                in_range_c;
  logic                gnt_c;
  logic                rd_fire_c;
  logic [BankW-1:0]    addr_bank_c;
  logic [RowW-1:0]     addr_row_c;
  logic                mem_we_c;
  logic [BankW-1:0]    mem_bank_c;
  logic [RowW-1:0]     mem_row_c;
  logic [NumBytes-1:0] mem_be_c;
  logic [Width-1:0]    mem_wdata_c;
  logic [Width-1:0]    rd_word_c;

  // Address decode and grant; out-of-range accesses are still granted
  always_comb begin : p_decode
    in_range_c  = 32'(bus.addr_i) < Depth;
    addr_bank_c = BankW'(32'(bus.addr_i) / BankDepth);
    addr_row_c  = RowW'(32'(bus.addr_i) % BankDepth);
    gnt_c       = (state_q == StReady) && bus.req_i;
    rd_fire_c   = gnt_c && !bus.we_i;
  end

  // Array write port: the fill counter owns it during INIT, the bus otherwise
  always_comb begin : p_port
    mem_we_c    = 1'b0;
    mem_bank_c  = addr_bank_c;
    mem_row_c   = addr_row_c;
    mem_be_c    = bus.wmask_i;
    mem_wdata_c = bus.wdata_i;
    if (state_q == StInit) begin
      mem_we_c    = 1'b1;
      mem_bank_c  = BankW'(32'(cnt_q) / BankDepth);
      mem_row_c   = RowW'(32'(cnt_q) % BankDepth);
      mem_be_c    = '1;
      mem_wdata_c = '0;
    end else if (gnt_c && bus.we_i && in_range_c) begin
      mem_we_c = 1'b1;
    end
  end

  // Banked storage; only the selected bank sees a write enable
  always_ff @(posedge clk_i) begin : p_mem
    for (int b = 0; b < NumBanks; b++) begin
      if (mem_we_c && (mem_bank_c == BankW'(b))) begin
        for (int i = 0; i < NumBytes; i++) begin
          if (mem_be_c[i]) begin
            mem_q[b][mem_row_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
          end
        end
      end
    end
  end

  assign rd_word_c = mem_q[addr_bank_c][addr_row_c];

  // Fill/ready FSM plus the registered read response
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_fsm
    if (!rst_ni) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rerror_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rvalid_q <= rd_fire_c;
      // rdata holds between reads; out-of-range reads return zero
      if (rd_fire_c) begin
        rerror_q <= !in_range_c;
        rdata_q  <= in_range_c ? rd_word_c : '0;
      end
      case (state_q)
        StInit: begin
          if (cnt_q == CntW'(Depth - 1)) begin
            state_q     <= StReady;
            cnt_q       <= '0;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StReady: begin
          if (init_req_i) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StInit;
          cnt_q       <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_o    = gnt_c;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.rerror_o = rerror_q;
  assign init_done_o  = init_done_q;

endmodule
